// File: rtl/jtag_pkg.sv
// Shared opcodes, data-register selects and decode bundle for the
// JTAG instruction register of the ripple-adder DFT wrapper.
package jtag_pkg;

  localparam int unsigned IR_MAX = 8;

  localparam logic [IR_MAX-1:0] OP_EXTEST = 8'h00;
  localparam logic [IR_MAX-1:0] OP_SAMPLE = 8'h01;
  localparam logic [IR_MAX-1:0] OP_INTEST = 8'h02;
  localparam logic [IR_MAX-1:0] OP_IDCODE = 8'h03;
  localparam logic [IR_MAX-1:0] OP_CLAMP  = 8'h04;
  localparam logic [IR_MAX-1:0] OP_HIGHZ  = 8'h05;

  localparam logic [IR_MAX-1:0] CAPTURE_PAT = 8'h01;

  typedef enum logic [1:0] {
    DR_BSR    = 2'd0,
    DR_BYPASS = 2'd1,
    DR_IDCODE = 2'd2
  } dr_sel_e;

  typedef struct packed {
    logic    mode;
    dr_sel_e dr_sel;
    logic    clamp;
    logic    highz;
    logic    valid;
  } decode_t;

  // BYPASS is all-ones at whatever width the register is built
  function automatic logic [IR_MAX-1:0] op_bypass(
    input int unsigned w
  );
    return 8'hFF >> (IR_MAX - w);
  endfunction

endpackage

// File: rtl/jtag_instr_decode.sv
// Combinational decode of the committed instruction into
// boundary-scan mode, DR select, clamp and high-Z controls.
module jtag_instr_decode
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 4
) (
  input  logic [IR_WIDTH-1:0] ir,
  output logic                mode,
  output logic [1:0]          dr_sel,
  output logic                clamp,
  output logic                highz,
  output logic                instr_valid
);

  logic [IR_MAX-1:0] op;
  logic              is_bypass;
  decode_t           d;

  assign op        = IR_MAX'(ir);
  assign is_bypass = (op == op_bypass(IR_WIDTH));

  always_comb begin
    d = '{mode: 1'b0, dr_sel: DR_BYPASS,
          clamp: 1'b0, highz: 1'b0, valid: 1'b0};
    if (is_bypass) begin
      d.valid = 1'b1;
    end else begin
      case (op)
        OP_EXTEST: d = '{1'b1, DR_BSR, 1'b0, 1'b0, 1'b1};
        OP_SAMPLE: d = '{1'b0, DR_BSR, 1'b0, 1'b0, 1'b1};
        OP_INTEST: d = '{1'b1, DR_BSR, 1'b0, 1'b0, 1'b1};
        OP_IDCODE: begin
          d = '{1'b0, DR_IDCODE, 1'b0, 1'b0, 1'b1};
        end
        OP_CLAMP: d = '{1'b1, DR_BYPASS, 1'b1, 1'b0, 1'b1};
        OP_HIGHZ: d = '{1'b1, DR_BYPASS, 1'b0, 1'b1, 1'b1};
        // undefined codes fall back to bypass, flagged invalid
        default: d.valid = 1'b0;
      endcase
    end
  end

  assign mode        = d.mode;
  assign dr_sel      = d.dr_sel;
  assign clamp       = d.clamp;
  assign highz       = d.highz;
  assign instr_valid = d.valid;

endmodule

// File: rtl/jtag_ir_decoder.sv
// JTAG instruction register: capture/shift stage, update shadow,
// strobe priority and instruction decode.
module jtag_ir_decoder
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH  = 4,
  parameter bit          IDCODE_EN = 1'b1
) (
  input  logic                TCK,
  input  logic                TRST_n,
  input  logic                tlr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                tdi,
  output logic                ir_tdo,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic                Mode,
  output logic [1:0]          dr_sel,
  output logic                clamp,
  output logic                highz,
  output logic                instr_valid
);

  localparam logic [IR_WIDTH-1:0] CAP =
    CAPTURE_PAT[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_RST =
    IDCODE_EN ? OP_IDCODE[IR_WIDTH-1:0]
              : {IR_WIDTH{1'b1}};

  logic [IR_WIDTH-1:0] shift_q;
  logic                rst;

  assign rst = !TRST_n || tlr;

  // reset > update > capture > shift; one action per edge
  always_ff @(posedge TCK) begin
    if (rst) begin
      ir_q    <= IR_RST;
      shift_q <= CAP;
    end else if (update_ir) begin
      ir_q <= shift_q;
    end else if (capture_ir) begin
      shift_q <= CAP;
    end else if (shift_ir) begin
      shift_q <= {tdi, shift_q[IR_WIDTH-1:1]};
    end
  end

  assign ir_tdo = shift_q[0];

  jtag_instr_decode #(
    .IR_WIDTH(IR_WIDTH)
  ) u_decode (
    .ir         (ir_q),
    .mode       (Mode),
    .dr_sel     (dr_sel),
    .clamp      (clamp),
    .highz      (highz),
    .instr_valid(instr_valid)
  );

endmodule

// File: tb/tb_jtag_ir_decoder.sv
// Scoreboard bench for jtag_ir_decoder: a 4-bit IDCODE-reset
// instance and a 3-bit BYPASS-reset instance.
module tb_jtag_ir_decoder;

  logic TCK = 1'b0;
  always #5 TCK = ~TCK;

  logic       a_trst, a_tlr, a_cap, a_sh, a_upd, a_tdi;
  logic       a_tdo, a_mode, a_clamp, a_highz, a_valid;
  logic [3:0] a_ir;
  logic [1:0] a_dr;

  logic       b_trst, b_tlr, b_cap, b_sh, b_upd, b_tdi;
  logic       b_tdo, b_mode, b_clamp, b_highz, b_valid;
  logic [2:0] b_ir;
  logic [1:0] b_dr;

  jtag_ir_decoder #(.IR_WIDTH(4), .IDCODE_EN(1'b1)) dut_a (
    .TCK(TCK), .TRST_n(a_trst), .tlr(a_tlr),
    .capture_ir(a_cap), .shift_ir(a_sh), .update_ir(a_upd),
    .tdi(a_tdi), .ir_tdo(a_tdo), .ir_q(a_ir), .Mode(a_mode),
    .dr_sel(a_dr), .clamp(a_clamp), .highz(a_highz),
    .instr_valid(a_valid)
  );

  jtag_ir_decoder #(.IR_WIDTH(3), .IDCODE_EN(1'b0)) dut_b (
    .TCK(TCK), .TRST_n(b_trst), .tlr(b_tlr),
    .capture_ir(b_cap), .shift_ir(b_sh), .update_ir(b_upd),
    .tdi(b_tdi), .ir_tdo(b_tdo), .ir_q(b_ir), .Mode(b_mode),
    .dr_sel(b_dr), .clamp(b_clamp), .highz(b_highz),
    .instr_valid(b_valid)
  );

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [13:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge TCK) cyc <= cyc + 1;

  // {ir[7:0], mode, dr[1:0], clamp, highz, valid, tdo} minus one bit
  function automatic logic [13:0] pack(
    input logic [7:0] ir, input logic m, input logic [1:0] dr,
    input logic c, input logic h, input logic v, input logic t
  );
    return {ir[6:0], m, dr, c, h, v, t};
  endfunction

  always @(negedge TCK) begin
    logic [13:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.dut == 0)
        act = pack(8'(a_ir), a_mode, a_dr, a_clamp, a_highz,
                   a_valid, a_tdo);
      else
        act = pack(8'(b_ir), b_mode, b_dr, b_clamp, b_highz,
                   b_valid, b_tdo);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation missed at cycle %0d",
                 e.name, cyc);
      end else if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got %h expected %h (ir,m,dr,c,h,v,tdo)",
                 e.name, act, e.vec);
      end
    end
  end

  task automatic expect_st(
    input int dut, input string name, input logic [7:0] ir,
    input logic m, input logic [1:0] dr, input logic c,
    input logic h, input logic v, input logic t
  );
    exp_t e;
    e.cyc  = cyc + 1;
    e.dut  = dut;
    e.name = name;
    e.vec  = pack(ir, m, dr, c, h, v, t);
    q.push_back(e);
  endtask

  task automatic step_a(
    input logic trst, input logic tl, input logic cap,
    input logic sh, input logic upd, input logic d
  );
    @(negedge TCK);
    #1;
    a_trst = trst; a_tlr = tl; a_cap = cap;
    a_sh = sh; a_upd = upd; a_tdi = d;
  endtask

  task automatic step_b(
    input logic trst, input logic cap,
    input logic sh, input logic upd, input logic d
  );
    @(negedge TCK);
    #1;
    b_trst = trst; b_cap = cap;
    b_sh = sh; b_upd = upd; b_tdi = d;
  endtask

  // A: idle-at-idcode expectation shortcut
  task automatic exp_a_id(input string name, input logic t);
    expect_st(0, name, 8'h03, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, t);
  endtask

  initial begin
    a_trst = 0; a_tlr = 0; a_cap = 0; a_sh = 0; a_upd = 0;
    a_tdi = 0;
    b_trst = 0; b_tlr = 0; b_cap = 0; b_sh = 0; b_upd = 0;
    b_tdi = 0;

    // reset both for two cycles
    for (int i = 0; i < 2; i++) begin
      step_a(0, 0, 0, 0, 0, 0);
      exp_a_id("rst_a", 1'b1);
      expect_st(1, "rst_b", 8'h07, 1'b0, 2'd1, 1'b0, 1'b0,
                1'b1, 1'b1);
    end
    b_trst = 1;
    step_a(1, 0, 0, 0, 0, 0);
    exp_a_id("hold_a", 1'b1);

    // EXTEST: capture, shift 0000, update
    step_a(1, 0, 1, 0, 0, 0);
    exp_a_id("ext_cap", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step_a(1, 0, 0, 1, 0, 0);
      exp_a_id("ext_sh", 1'b0);
    end
    step_a(1, 0, 0, 0, 1, 0);
    expect_st(0, "ext_upd", 8'h00, 1'b1, 2'd0, 1'b0, 1'b0,
              1'b1, 1'b0);

    // TLR acts as reset
    step_a(1, 1, 0, 0, 0, 0);
    exp_a_id("tlr", 1'b1);

    // HIGHZ = 5, tdi 1,0,1,0
    step_a(1, 0, 1, 0, 0, 0);
    exp_a_id("hz_cap", 1'b1);
    step_a(1, 0, 0, 1, 0, 1); exp_a_id("hz_s1", 1'b0);
    step_a(1, 0, 0, 1, 0, 0); exp_a_id("hz_s2", 1'b0);
    step_a(1, 0, 0, 1, 0, 1); exp_a_id("hz_s3", 1'b0);
    step_a(1, 0, 0, 1, 0, 0); exp_a_id("hz_s4", 1'b1);
    step_a(1, 0, 0, 0, 1, 0);
    expect_st(0, "hz_upd", 8'h05, 1'b1, 2'd1, 1'b0, 1'b1,
              1'b1, 1'b1);

    // CLAMP = 4, tdi 0,0,1,0
    step_a(1, 0, 1, 0, 0, 0);
    expect_st(0, "cl_cap", 8'h05, 1'b1, 2'd1, 1'b0, 1'b1,
              1'b1, 1'b1);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 1, 0, 1);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 0, 1, 0);
    expect_st(0, "cl_upd", 8'h04, 1'b1, 2'd1, 1'b1, 1'b0,
              1'b1, 1'b0);

    // undefined 9, tdi 1,0,0,1
    step_a(1, 0, 1, 0, 0, 0);
    step_a(1, 0, 0, 1, 0, 1);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 1, 0, 1);
    expect_st(0, "und_s4", 8'h04, 1'b1, 2'd1, 1'b1, 1'b0,
              1'b1, 1'b1);
    step_a(1, 0, 0, 0, 1, 0);
    expect_st(0, "und_upd", 8'h09, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b0, 1'b1);

    // shift_q -> 1000, then update+capture: update only
    step_a(1, 0, 1, 0, 0, 0);
    step_a(1, 0, 0, 1, 0, 0);
    step_a(1, 0, 0, 1, 0, 1);
    step_a(1, 0, 1, 0, 1, 0);
    expect_st(0, "upd_over_cap", 8'h08, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b0, 1'b0);
    // capture+shift: capture only
    step_a(1, 0, 1, 1, 0, 1);
    expect_st(0, "cap_over_sh", 8'h08, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b0, 1'b1);
    step_a(1, 0, 0, 0, 0, 0);
    expect_st(0, "idle_hold", 8'h08, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b0, 1'b1);

    // reset after 2 of 4 shifts (shift still asserted)
    step_a(1, 0, 0, 1, 0, 1);
    step_a(1, 0, 0, 1, 0, 1);
    expect_st(0, "mid_s2", 8'h08, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b0, 1'b0);
    step_a(0, 0, 0, 1, 0, 1);
    exp_a_id("mid_rst", 1'b1);
    step_a(1, 0, 0, 1, 0, 0); exp_a_id("post_s1", 1'b0);
    step_a(1, 0, 0, 1, 0, 0); exp_a_id("post_s2", 1'b0);
    // reset beats update
    step_a(0, 0, 0, 0, 1, 0);
    exp_a_id("rst_over_upd", 1'b1);
    step_a(1, 0, 0, 0, 0, 0);

    // B: INTEST = 3'b010, tdi 0,1,0
    step_b(1, 1, 0, 0, 0);
    expect_st(1, "b_cap", 8'h07, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b1, 1'b1);
    step_b(1, 0, 1, 0, 0);
    step_b(1, 0, 1, 0, 1);
    step_b(1, 0, 1, 0, 0);
    expect_st(1, "b_s3", 8'h07, 1'b0, 2'd1, 1'b0, 1'b0,
              1'b1, 1'b0);
    step_b(1, 0, 0, 1, 0);
    expect_st(1, "b_intest", 8'h02, 1'b1, 2'd0, 1'b0, 1'b0,
              1'b1, 1'b0);
    step_b(1, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) @(negedge TCK);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #20000;
    join_any
    disable fork;
    if (!done) begin
      errors++;
      $display("FAIL timeout: done=%0d required 1", done);
    end
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL leftover: %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_ir_decoder.md
# jtag_ir_decoder

Parametrised JTAG instruction register with an integrated instruction decoder for the ripple-adder DFT wrapper. It captures, shifts and updates an IR_WIDTH-bit instruction under control of TAP-controller state strobes. It decodes the updated instruction into boundary-scan mode, data-register select, clamp and high-Z controls. It sits between the TAP controller and the BSR/bypass/IDCODE data registers, and adds CLAMP, HIGHZ and IDCODE to the original 2-bit, four-instruction set.

## Interface
- IR_WIDTH, 4, instruction register width; legal range 3..8.
- IDCODE_EN, 1, 1: reset instruction is IDCODE; 0: reset instruction is BYPASS.
- TCK  input  1  test clock; all state updates on rising edge.
- TRST_n  input  1  reset, synchronous, active-low.
- tlr  input  1  TAP in Test-Logic-Reset; behaves as a synchronous reset.
- capture_ir  input  1  TAP in Capture-IR.
- shift_ir  input  1  TAP in Shift-IR.
- update_ir  input  1  TAP in Update-IR.
- tdi  input  1  serial data in.
- ir_tdo  output  1  serial data out = shift_q[0] (combinational from register).
- ir_q  output  IR_WIDTH  current (updated) instruction.
- Mode  output  1  1: BSR drives core/pins (test mode); 0: functional path.
- dr_sel  output  2  0 = BSR, 1 = BYPASS, 2 = IDCODE; 3 is never driven.
- clamp  output  1  CLAMP active.
- highz  output  1  HIGHZ active; pads tri-stated.
- instr_valid  output  1  0 when ir_q holds an undefined opcode.

## Operation
- Opcodes: EXTEST=0, SAMPLE_PRELOAD=1, INTEST=2, IDCODE=3, CLAMP=4, HIGHZ=5, BYPASS=all-ones. All other codes are undefined and decode as BYPASS with instr_valid=0.
- Decode per instruction as Mode/dr_sel/clamp/highz:
  - EXTEST: 1/0/0/0
  - SAMPLE_PRELOAD: 0/0/0/0
  - INTEST: 1/0/0/0
  - IDCODE: 0/2/0/0
  - CLAMP: 1/1/1/0
  - HIGHZ: 1/1/0/1
  - BYPASS and undefined: 0/1/0/0
- Two registers:
  - shift_q (IR_WIDTH): the serial stage.
  - ir_q (IR_WIDTH): the shadow/update stage.
- Capture: shift_q <= {zeros, 2'b01}, per 1149.1.
- Shift: shift_q <= {tdi, shift_q[IR_WIDTH-1:1]}. LSB leaves first on ir_tdo; tdi enters at MSB.
- Update: ir_q <= shift_q.
- Reset (TRST_n=0 or tlr=1):
  - ir_q <= IDCODE if IDCODE_EN else BYPASS.
  - shift_q <= {zeros, 2'b01}.
- Strobe priority when several are asserted: reset > update_ir > capture_ir > shift_ir. Only the highest-priority action occurs. The TAP never asserts more than one, but the block must be deterministic if it does.
- No strobe asserted: both registers hold.
- shift_q is not cleared by update. ir_q is never disturbed by capture or shift.

## Timing
- Decode is combinational from ir_q, so outputs change in the cycle after the update_ir edge (1-cycle latency from update strobe).
- ir_tdo reflects shift_q. The first shifted-out bit is valid the cycle after capture_ir, and the next bit appears one cycle after each shift_ir cycle.
- A full instruction load takes IR_WIDTH consecutive shift_ir cycles. Fewer cycles leave a partially shifted value, and update commits it as-is.
- Reset mid-shift: shift_q returns to the capture pattern and ir_q to the reset instruction on the same edge. Outputs show reset decode the following cycle.
- Reset values (IDCODE_EN=1):
  - ir_q=3, Mode=0, dr_sel=2, clamp=0, highz=0, instr_valid=1, ir_tdo=1.
- Reset values (IDCODE_EN=0):
  - ir_q=all-ones, dr_sel=1, others as above.

## Structure
- Package jtag_pkg holds:
  - opcode constants, with BYPASS defined as all-ones of IR_WIDTH;
  - dr_sel encodings DR_BSR/DR_BYPASS/DR_IDCODE;
  - the capture pattern.
- Sub-module jtag_instr_decode: purely combinational decode of ir_q to Mode/dr_sel/clamp/highz/instr_valid, parametrised by IR_WIDTH.
- The top level contains the two registers and the strobe priority logic.

## Test plan
- Reset: TRST_n low 2 cycles, IDCODE_EN=1 -> ir_q=4'h3, dr_sel=2, Mode=0, ir_tdo=1. Repeat with tlr=1 and the same result.
- Load EXTEST (IR_WIDTH=4): capture, shift tdi=0,0,0,0, update.
  - ir_tdo sequence 1,0,0,0.
  - Next cycle Mode=1, dr_sel=0.
- Load HIGHZ (5 = tdi 1,0,1,0 LSB first) then update -> highz=1, Mode=1, dr_sel=1, clamp=0. Then load CLAMP (4) -> clamp=1, highz=0.
- Undefined opcode 4'h9 -> dr_sel=1, Mode=0, instr_valid=0.
- Priority and reset mid-op:
  - Assert update_ir with capture_ir -> only update occurs.
  - TRST_n low after 2 of 4 shift cycles -> ir_q=3 and shift_q=4'b0001 next edge.
- IR_WIDTH=3, IDCODE_EN=0 -> reset ir_q=3'b111, dr_sel=1. Shift 3 bits of 3'b010 -> INTEST decode.
